tate_pairing_host_if: RTL
=========================

TATE_PAIRING_HOST_IF -- requirements
Module: tate_pairing_host_if

Interface
REQ-001 Parameters: none; widths SHALL come from the shared include: `WIDTH:0 is one F(3^m) element (2*`M bits), `W6:0 is one F(3^6m) element (six F(3^m) elements).
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand beat valid.
REQ-005 in_ready  output  1  bridge accepts an operand beat.
REQ-006 in_data  input  `WIDTH+1  one operand element per beat, in the order x1, y1, x2, y2.
REQ-007 core_reset  output  1  drives the pairing core's synchronous reset (start pulse).
REQ-008 core_x1, core_y1, core_x2, core_y2  output  `WIDTH+1 each  operand registers feeding the core.
REQ-009 core_done  input  1  core completion flag; low during and after a core reset, high once the result is valid.
REQ-010 core_out  input  `W6+1  core result.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  consumer accepts a result beat.
REQ-013 out_data  output  `WIDTH+1  one result element per beat.
REQ-014 out_last  output  1  high on the sixth (final) result beat.
REQ-015 busy  output  1  high in every state except LOAD.

Function
REQ-016 FSM states SHALL be LOAD, KICK, GUARD, WAIT and SEND; transitions occur on the clock edge only.
REQ-017 LOAD behaviour:
- in_ready = 1.
- Each handshake (in_valid & in_ready) writes in_data into operand register idx (0=x1, 1=y1, 2=x2, 3=y2) and increments a 2-bit idx.
- The handshake that writes y2 (idx=3) moves the FSM to KICK and wraps idx to 0.
REQ-018 in_ready SHALL be 0 in all states other than LOAD; in_valid outside LOAD is ignored and no operand register changes.
REQ-019 KICK behaviour:
- core_reset = 1 for exactly one cycle.
- Next state is GUARD.
- Operand registers SHALL remain stable from KICK until the FSM returns to LOAD.
REQ-020 GUARD lasts 2 cycles (2-bit counter) and core_done SHALL be ignored during it, so that a stale high from the previous run is never taken as completion; next state is WAIT.
REQ-021 WAIT:
- On core_done = 1, capture core_out into a `W6+1 result register in the same edge.
- Clear the beat counter (0..5) and go to SEND.
REQ-022 SEND behaviour:
- out_valid = 1.
- out_data = result element k, where k is the beat counter; element 0 is the least-significant `WIDTH+1 bits of the captured result and element 5 is the most-significant.
- out_last = (k == 5).
REQ-023 In SEND, out_data and out_last SHALL hold steady while out_valid & ~out_ready (no beat dropped or repeated); each handshake advances k.
REQ-024 The handshake with k = 5 SHALL return the FSM to LOAD and clear out_valid in the same edge.
REQ-025 Back-to-back: a LOAD handshake is possible in the cycle immediately after the final SEND handshake.
REQ-026 The result register SHALL be read only from the captured copy; core_out changes during SEND do not affect out_data.
REQ-027 Latency:
- Last operand handshake to core_reset high: 1 cycle.
- core_done sampled high to out_valid high: 1 cycle.
REQ-028 out_valid, out_last and core_reset SHALL be driven from registers or from state decode with no combinational path from in_valid or out_ready.

Reset
REQ-029 On reset the bridge SHALL enter LOAD with in_ready=1 and the following outputs cleared: idx=0, k=0, out_valid=0, out_last=0, core_reset=0, busy=0, and operand registers and result register all zero.
REQ-030 Reset asserted in any state (mid-load, WAIT, mid-SEND) SHALL abort the operation in the next cycle: partial operands are discarded, pending result beats are discarded, and no further out_valid is produced.

Verification
REQ-031 Load x1=1, y1=2, x2=3, y2=4 with in_valid held high -> 4 beats accepted in 4 cycles, core_reset high for 1 cycle, core_x1..core_y2 = 1,2,3,4, busy=1.
REQ-032 Hold core_done=1 continuously from KICK -> completion not taken during GUARD; capture happens on the first WAIT cycle and out_valid rises 1 cycle later.
REQ-033 Drive core_out with element i = i+10 (i=0..5) and out_ready=1 -> out_data 10,11,12,13,14,15 on 6 consecutive cycles, out_last only on 15, then in_ready=1.
REQ-034 Toggle out_ready 1,0,0,1,... during SEND -> every element emitted exactly once, in order, with data stable during stalls.
REQ-035 Assert reset after 2 operand beats and again mid-SEND (after beat 3) -> LOAD, in_ready=1, out_valid=0; the next 4-beat load starts at x1.
REQ-036 Drive in_valid high during WAIT and SEND -> in_ready=0 and operand registers unchanged.

Source files
------------

// File: rtl/tate_pairing_host_if.sv
`default_nettype none
//============================================================================
// Module   : tate_pairing_host_if
// Brief    : Streaming host bridge for the Tate pairing core. Collects four
//            F(3^m) operands over a valid/ready port, pulses the core reset
//            to start it, waits for completion and streams the six-element
//            F(3^6m) result back out, one element per beat.
// Revision : 1.0  initial release
//============================================================================

// Field widths shared with the pairing core; guarded so an existing include
// defining them takes precedence.
`ifndef M
`define M 97
`endif
`ifndef WIDTH
`define WIDTH (2*`M-1)
`endif
`ifndef W6
`define W6 (6*(`WIDTH+1)-1)
`endif

module tate_pairing_host_if (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [`WIDTH:0] in_data,
    output logic            core_reset,
    output logic [`WIDTH:0] core_x1,
    output logic [`WIDTH:0] core_y1,
    output logic [`WIDTH:0] core_x2,
    output logic [`WIDTH:0] core_y2,
    input  logic            core_done,
    input  logic [`W6:0]    core_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [`WIDTH:0] out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int c_ELEM_W = `WIDTH + 1;

    localparam logic [2:0] c_LOAD  = 3'd0;
    localparam logic [2:0] c_KICK  = 3'd1;
    localparam logic [2:0] c_GUARD = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_SEND  = 3'd4;

    logic [2:0]      r_state;
    logic [1:0]      r_idx;
    logic [1:0]      r_guard;
    logic [2:0]      r_k;
    logic [`W6:0]    r_result;
    logic [`WIDTH:0] r_x1, r_y1, r_x2, r_y2;

    logic w_in_fire;
    logic w_out_fire;

    // Handshakes are qualified by state only, so in_ready/out_valid never
    // depend combinationally on the partner's valid/ready.
    assign w_in_fire  = in_valid  && (r_state == c_LOAD);
    assign w_out_fire = out_ready && (r_state == c_SEND);

    // Control FSM plus operand and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_LOAD;
            r_idx    <= 2'd0;
            r_guard  <= 2'd0;
            r_k      <= 3'd0;
            r_result <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_x2     <= '0;
            r_y2     <= '0;
        end else begin
            case (r_state)
                c_LOAD: begin
                    if (w_in_fire) begin
                        case (r_idx)
                            2'd0:    r_x1 <= in_data;
                            2'd1:    r_y1 <= in_data;
                            2'd2:    r_x2 <= in_data;
                            default: r_y2 <= in_data;
                        endcase
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= c_KICK;
                        end
                    end
                end
                c_KICK: begin
                    r_guard <= 2'd0;
                    r_state <= c_GUARD;
                end
                // core_done may still be high from the previous run while the
                // core comes out of reset; ignore it for two cycles.
                c_GUARD: begin
                    r_guard <= r_guard + 2'd1;
                    if (r_guard == 2'd1) begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (core_done) begin
                        r_result <= core_out;
                        r_k      <= 3'd0;
                        r_state  <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (w_out_fire) begin
                        if (r_k == 3'd5) begin
                            r_k     <= 3'd0;
                            r_state <= c_LOAD;
                        end else begin
                            r_k <= r_k + 3'd1;
                        end
                    end
                end
                default: r_state <= c_LOAD;
            endcase
        end
    end

    // Select the current result element from the captured copy only.
    always_comb begin
        out_data = '0;
        case (r_k)
            3'd0:    out_data = r_result[0*c_ELEM_W +: c_ELEM_W];
            3'd1:    out_data = r_result[1*c_ELEM_W +: c_ELEM_W];
            3'd2:    out_data = r_result[2*c_ELEM_W +: c_ELEM_W];
            3'd3:    out_data = r_result[3*c_ELEM_W +: c_ELEM_W];
            3'd4:    out_data = r_result[4*c_ELEM_W +: c_ELEM_W];
            3'd5:    out_data = r_result[5*c_ELEM_W +: c_ELEM_W];
            default: out_data = '0;
        endcase
    end

    assign in_ready   = (r_state == c_LOAD);
    assign busy       = (r_state != c_LOAD);
    assign core_reset = (r_state == c_KICK);
    assign out_valid  = (r_state == c_SEND);
    assign out_last   = (r_state == c_SEND) && (r_k == 3'd5);

    assign core_x1 = r_x1;
    assign core_y1 = r_y1;
    assign core_x2 = r_x2;
    assign core_y2 = r_y2;

endmodule

`default_nettype wire
